// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host command sequencer.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_SEND,
        ST_WAIT_ACK,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        STAT_OK          = 2'b00,
        STAT_RESEND_FAIL = 2'b01,
        STAT_TIMEOUT     = 2'b10
    } status_t;

    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_host_cmd_ctrl_if.sv
// Command, response, PS/2 rx/tx and scan-code signals of the host command sequencer.
interface ps2_host_cmd_ctrl_if;

    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [1:0] rsp_status;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_done;
    logic       ps2_inhibit;
    logic [7:0] scan_data;
    logic       scan_valid;

    // System command logic plus the PS/2 receiver/transmitter pair.
    modport master (
        output cmd_valid, cmd_byte, rx_data, rx_valid, tx_done,
        input  cmd_ready, rsp_valid, rsp_status, tx_start, tx_byte,
               ps2_inhibit, scan_data, scan_valid
    );

    // The sequencer itself.
    modport slave (
        input  cmd_valid, cmd_byte, rx_data, rx_valid, tx_done,
        output cmd_ready, rsp_valid, rsp_status, tx_start, tx_byte,
               ps2_inhibit, scan_data, scan_valid
    );

endinterface

// File: rtl/ps2_cycle_timer.sv
// Saturating up-counter whose terminal count is loaded at the start of each phase.
module ps2_cycle_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
    input  logic             enable,
    output logic             tc
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] limit;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
            limit <= '0;
        end else if (load) begin
            count <= '0;
            limit <= load_value;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host command sequencer: inhibit, send, await ACK/RESEND with retry and timeout,
// and forward every other received byte as a scan code.
module ps2_host_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRY      = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ps2_host_cmd_ctrl_if.slave   bus
);

    localparam int TW = $clog2(max_int(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRY);

    state_t          state;
    state_t          next_state;
    status_t         status;
    status_t         status_d;
    logic [RW-1:0]   retry;
    logic            retry_inc;
    logic            rx_consumed;
    logic            send_first;
    logic [7:0]      tx_byte_q;
    logic [7:0]      scan_data_q;
    logic            scan_valid_q;

    logic            timer_load;
    logic [TW-1:0]   timer_limit;
    logic            timer_clear;
    logic            timer_en;
    logic            timer_tc;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        next_state  = state;
        status_d    = status;
        retry_inc   = 1'b0;
        rx_consumed = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) next_state = ST_INHIBIT;
            end
            ST_INHIBIT: begin
                if (timer_tc) next_state = ST_SEND;
            end
            ST_SEND: begin
                if (timer_tc) begin
                    next_state = ST_RESP;
                    status_d   = STAT_TIMEOUT;
                end else if (bus.tx_done) begin
                    next_state = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // A reply landing on the timeout cycle still counts as the reply.
                if (bus.rx_valid && (bus.rx_data == PS2_ACK)) begin
                    rx_consumed = 1'b1;
                    next_state  = ST_RESP;
                    status_d    = STAT_OK;
                end else if (bus.rx_valid && (bus.rx_data == PS2_RESEND)) begin
                    rx_consumed = 1'b1;
                    if (retry == RETRY_LAST) begin
                        next_state = ST_RESP;
                        status_d   = STAT_RESEND_FAIL;
                    end else begin
                        next_state = ST_INHIBIT;
                        retry_inc  = 1'b1;
                    end
                end else if (timer_tc) begin
                    next_state = ST_RESP;
                    status_d   = STAT_TIMEOUT;
                end
            end
            ST_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // One timer serves both phases: entering INHIBIT or SEND restarts it with that phase's limit.
    always_comb begin
        timer_load  = (next_state != state) &&
                      ((next_state == ST_INHIBIT) || (next_state == ST_SEND));
        timer_limit = (next_state == ST_INHIBIT) ? INHIBIT_LAST : TIMEOUT_LAST;
        timer_clear = (state == ST_IDLE);
        timer_en    = (state == ST_INHIBIT) || (state == ST_SEND) || (state == ST_WAIT_ACK);
    end

    ps2_cycle_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_limit),
        .clear      (timer_clear),
        .enable     (timer_en),
        .tc         (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            status       <= STAT_OK;
            retry        <= '0;
            send_first   <= 1'b0;
            tx_byte_q    <= '0;
            scan_valid_q <= 1'b0;
            scan_data_q  <= '0;
        end else begin
            state      <= next_state;
            status     <= status_d;
            send_first <= (next_state == ST_SEND) && (state != ST_SEND);
            if ((state == ST_IDLE) && bus.cmd_valid) begin
                tx_byte_q <= bus.cmd_byte;
                retry     <= '0;
            end else if (retry_inc) begin
                retry <= retry + RW'(1);
            end
            scan_valid_q <= bus.rx_valid && !rx_consumed;
            if (bus.rx_valid && !rx_consumed) scan_data_q <= bus.rx_data;
        end
    end

    assign bus.cmd_ready   = (state == ST_IDLE);
    assign bus.rsp_valid   = (state == ST_RESP);
    assign bus.rsp_status  = status;
    assign bus.tx_start    = (state == ST_SEND) && send_first;
    assign bus.tx_byte     = tx_byte_q;
    assign bus.ps2_inhibit = (state == ST_INHIBIT);
    assign bus.scan_data   = scan_data_q;
    assign bus.scan_valid  = scan_valid_q;

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Directed and randomized transactions checked against a transaction-level model of the sequencer.
module tb_ps2_host_cmd_ctrl;
    import ps2_pkg::*;

    localparam int INHIBIT_CYCLES = 4;
    localparam int TIMEOUT_CYCLES = 50;
    localparam int MAX_RETRY      = 2;

    // {cmd_ready, rsp_valid, rsp_status, tx_start, ps2_inhibit, scan_valid, tx_byte, scan_data}
    localparam logic [22:0] RESET_VEC = {1'b1, 22'd0};

    logic clk = 1'b0;
    logic reset_n;

    ps2_host_cmd_ctrl_if bus ();

    ps2_host_cmd_ctrl #(
        .INHIBIT_CYCLES (INHIBIT_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRY      (MAX_RETRY)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int tx_total = 0;
    int rsp_total = 0;
    logic [7:0] obs_scan[$];
    logic [7:0] exp_scan[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.tx_start) tx_total <= tx_total + 1;
        if (bus.rsp_valid) rsp_total <= rsp_total + 1;
        if (bus.scan_valid) obs_scan.push_back(bus.scan_data);
    end

    initial begin
        #1_000_000;
        $fatal(1, "FAIL watchdog: run did not reach its summary, observed hang expected finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [22:0] out_vec();
        return {bus.cmd_ready, bus.rsp_valid, bus.rsp_status, bus.tx_start,
                bus.ps2_inhibit, bus.scan_valid, bus.tx_byte, bus.scan_data};
    endfunction

    function automatic logic [7:0] rand_scan();
        logic [7:0] b;
        do b = 8'($urandom); while ((b == PS2_ACK) || (b == PS2_RESEND));
        return b;
    endfunction

    task automatic rx_pulse(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic idle_scan(input logic [7:0] b);
        rx_pulse(b);
        exp_scan.push_back(b);
        check("idle_scan", {bus.scan_valid, bus.scan_data}, {1'b1, b});
    endtask

    // Counts inhibit cycles (including the current one) and cycles until tx_start.
    task automatic wait_tx_start(output int inh, output int nt, output bit ok);
        inh = bus.ps2_inhibit ? 1 : 0;
        nt  = 0;
        ok  = 1'b0;
        while (!ok && (nt < 40)) begin
            tick();
            nt++;
            if (bus.ps2_inhibit) inh++;
            if (bus.tx_start) ok = 1'b1;
        end
    endtask

    task automatic wait_rsp(output bit ok);
        int nt;
        nt = 0;
        while (!bus.rsp_valid && (nt < TIMEOUT_CYCLES + 20)) begin
            tick();
            nt++;
        end
        ok = bus.rsp_valid;
    endtask

    // Model: each RESEND costs one more attempt up to MAX_RETRY+1 attempts; the final
    // reply (ACK, exhausted RESEND, or silence) decides the status.
    task automatic transaction(input logic [7:0] cmd, input int n_resend, input bit ack,
                               input bit do_scan, input logic [7:0] scan_b);
        int         exp_tx;
        int         inh;
        int         nt;
        int         tx0;
        int         rsp0;
        int         send_cyc;
        bit         ok;
        logic [1:0] exp_status;
        exp_tx = (n_resend > MAX_RETRY) ? MAX_RETRY + 1 : n_resend + 1;
        if (n_resend > MAX_RETRY) exp_status = 2'b01;
        else if (ack)             exp_status = 2'b00;
        else                      exp_status = 2'b10;
        tx0      = tx_total;
        rsp0     = rsp_total;
        send_cyc = cyc;

        check("ready_before", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_byte  = cmd;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_byte  = 8'($urandom);
        check("busy_ready", bus.cmd_ready, 0);

        for (int a = 0; a < exp_tx; a++) begin
            wait_tx_start(inh, nt, ok);
            check("tx_start_seen", ok, 1);
            check("inhibit_len", inh, INHIBIT_CYCLES);
            check("inhibit_to_tx", nt, INHIBIT_CYCLES);
            check("tx_byte", bus.tx_byte, cmd);
            send_cyc = cyc;
            repeat ($urandom_range(0, 3)) tick();
            bus.tx_done = 1'b1;
            tick();
            bus.tx_done = 1'b0;
            if (do_scan) begin
                rx_pulse(scan_b);
                exp_scan.push_back(scan_b);
                check("wait_scan", {bus.scan_valid, bus.scan_data}, {1'b1, scan_b});
            end
            repeat ($urandom_range(0, 3)) tick();
            if (a < n_resend) begin
                rx_pulse(PS2_RESEND);
                check("resend_consumed", bus.scan_valid, 0);
            end else if (ack) begin
                rx_pulse(PS2_ACK);
                check("ack_consumed", bus.scan_valid, 0);
            end else begin
                wait_rsp(ok);
                check("timeout_seen", ok, 1);
                check("timeout_latency", cyc - send_cyc, TIMEOUT_CYCLES);
            end
        end

        check("rsp", {bus.rsp_valid, bus.rsp_status}, {1'b1, exp_status});
        tick();
        check("rsp_done", {bus.rsp_valid, bus.cmd_ready, bus.rsp_status}, {1'b0, 1'b1, exp_status});
        check("tx_count", tx_total - tx0, exp_tx);
        check("rsp_count", rsp_total - rsp0, 1);
        check("scan_count", obs_scan.size(), exp_scan.size());
    endtask

    initial begin
        int inh;
        int nt;
        int tx0;
        int rsp0;
        bit ok;

        reset_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_byte  = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.tx_done   = 1'b0;
        repeat (3) tick();
        check("reset_hold", out_vec(), RESET_VEC);
        reset_n = 1'b1;
        tick();
        check("reset_release", out_vec(), RESET_VEC);

        transaction(8'hED, 0, 1'b1, 1'b0, 8'h00);
        transaction(8'hF4, 3, 1'b0, 1'b0, 8'h00);
        transaction(8'hFF, 0, 1'b0, 1'b0, 8'h00);
        transaction(8'hF2, 0, 1'b1, 1'b1, 8'h1C);
        idle_scan(8'h1C);
        idle_scan(PS2_ACK);
        idle_scan(PS2_RESEND);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) != 0) idle_scan(8'($urandom));
            transaction(8'($urandom), int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                        $urandom_range(0, 1) != 0, rand_scan());
        end

        // A command held valid while busy is taken only once the sequencer is back in IDLE.
        bus.cmd_valid = 1'b1;
        bus.cmd_byte  = 8'h55;
        tick();
        bus.cmd_byte  = 8'hF3;
        check("hold_busy", bus.cmd_ready, 0);
        wait_tx_start(inh, nt, ok);
        check("hold_tx", {ok, bus.tx_byte}, {1'b1, 8'h55});
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        check("hold_wait", {bus.cmd_ready, bus.tx_byte}, {1'b0, 8'h55});
        rx_pulse(PS2_ACK);
        check("hold_rsp", {bus.rsp_valid, bus.cmd_ready, bus.tx_byte}, {1'b1, 1'b0, 8'h55});
        tick();
        check("hold_idle", {bus.cmd_ready, bus.tx_byte}, {1'b1, 8'h55});
        tick();
        bus.cmd_valid = 1'b0;
        check("hold_accept", {bus.cmd_ready, bus.ps2_inhibit, bus.tx_byte}, {1'b0, 1'b1, 8'hF3});

        // ACK value outside WAIT_ACK is a scan code; then reset aborts the transaction.
        rx_pulse(PS2_ACK);
        exp_scan.push_back(PS2_ACK);
        check("inhibit_scan", {bus.ps2_inhibit, bus.scan_valid, bus.scan_data}, {1'b1, 1'b1, PS2_ACK});
        tx0  = tx_total;
        rsp0 = rsp_total;
        reset_n = 1'b0;
        tick();
        check("reset_mid", {bus.ps2_inhibit, bus.rsp_valid}, 2'b00);
        reset_n = 1'b1;
        tick();
        tick();
        check("reset_mid_vec", out_vec(), RESET_VEC);
        check("reset_no_rsp", rsp_total - rsp0, 0);
        check("reset_no_tx", tx_total - tx0, 0);

        check("scan_total", obs_scan.size(), exp_scan.size());
        for (int i = 0; (i < exp_scan.size()) && (i < obs_scan.size()); i++) begin
            check("scan_order", obs_scan[i], exp_scan[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
